// File: rtl/router_pkt_reg_p.sv
// ============================================================================
// Module   : router_pkt_reg_p
// Purpose  : 1x3 router packet register. It captures the header, buffers one
//            byte while the FIFO is full, and checks parity and payload length.
// Option   : ROUTER_ERR_CNT_EN adds a saturating errored-packet counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module router_pkt_reg_p #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              pkt_valid,
    input  logic [DATA_W-1:0] data_in,
    input  logic              fifo_full,
    input  logic              rst_in_reg,
    input  logic              detect_add,
    input  logic              lfd_state,
    input  logic              ld_state,
    input  logic              laf_state,
    input  logic              full_state,
    output logic [DATA_W-1:0] d_out,
    output logic              parity_done,
    output logic              low_pkt_valid,
    output logic              err,
    output logic              len_err,
    output logic [CNT_W-1:0]  err_cnt
);

    localparam int LEN_W = DATA_W - ADDR_W;

    logic [DATA_W-1:0] r_hdr;
    logic [DATA_W-1:0] r_hold;
    logic [DATA_W-1:0] r_d_out;
    logic [DATA_W-1:0] r_int_par;
    logic [DATA_W-1:0] r_pkt_par;
    logic [LEN_W-1:0]  r_pay_cnt;
    logic              r_ovf;
    logic              r_parity_done;
    logic              r_low_pkt_valid;
    logic              r_err;
    logic              r_len_err;

    logic w_accept;
    logic w_par_direct;
    logic w_par_held;
    logic w_cnt_max;

    // The FIFO_FULL state needs no action here; the held byte is already parked.
    logic w_unused;
    assign w_unused = full_state;

    assign w_accept     = ld_state && pkt_valid;
    assign w_par_direct = ld_state && !pkt_valid && !fifo_full;
    assign w_par_held   = laf_state && r_low_pkt_valid && !r_parity_done;
    assign w_cnt_max    = (r_pay_cnt == {LEN_W{1'b1}});

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_hdr           <= '0;
            r_hold          <= '0;
            r_d_out         <= '0;
            r_int_par       <= '0;
            r_pkt_par       <= '0;
            r_pay_cnt       <= '0;
            r_ovf           <= 1'b0;
            r_parity_done   <= 1'b0;
            r_low_pkt_valid <= 1'b0;
            r_err           <= 1'b0;
            r_len_err       <= 1'b0;
        end else begin
            if (detect_add && pkt_valid)
                r_hdr <= data_in;
            if (ld_state && fifo_full)
                r_hold <= data_in;

            if (lfd_state)
                r_d_out <= r_hdr;
            else if (ld_state && !fifo_full)
                r_d_out <= data_in;
            else if (laf_state)
                r_d_out <= r_hold;

            if (detect_add)
                r_int_par <= '0;
            else if (lfd_state)
                r_int_par <= r_hdr;
            else if (w_accept)
                r_int_par <= r_int_par ^ data_in;
            else if (!pkt_valid && rst_in_reg)
                r_int_par <= '0;

            // The counter sticks at its maximum; ovf remembers that a byte was lost.
            if (detect_add) begin
                r_pay_cnt <= '0;
                r_ovf     <= 1'b0;
            end else if (w_accept) begin
                if (w_cnt_max)
                    r_ovf <= 1'b1;
                else
                    r_pay_cnt <= r_pay_cnt + LEN_W'(1);
            end

            if (detect_add)
                r_pkt_par <= '0;
            else if (w_par_direct)
                r_pkt_par <= data_in;
            else if (w_par_held)
                r_pkt_par <= r_hold;

            if (w_par_direct || w_par_held)
                r_parity_done <= 1'b1;
            else if (detect_add)
                r_parity_done <= 1'b0;

            if (rst_in_reg)
                r_low_pkt_valid <= 1'b0;
            else if (ld_state && !pkt_valid)
                r_low_pkt_valid <= 1'b1;

            r_err     <= r_parity_done && (r_int_par != r_pkt_par);
            r_len_err <= r_parity_done && (r_ovf || (r_pay_cnt != r_hdr[DATA_W-1:ADDR_W]));
        end
    end

    assign d_out         = r_d_out;
    assign parity_done   = r_parity_done;
    assign low_pkt_valid = r_low_pkt_valid;
    assign err           = r_err;
    assign len_err       = r_len_err;

`ifdef ROUTER_ERR_CNT_EN
    logic             r_any_err_d;
    logic [CNT_W-1:0] r_err_cnt;
    logic             w_any_err;

    assign w_any_err = r_err || r_len_err;

    // Count only the rising edge, so a packet with both errors counts once.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_any_err_d <= 1'b0;
            r_err_cnt   <= '0;
        end else begin
            r_any_err_d <= w_any_err;
            if (w_any_err && !r_any_err_d && (r_err_cnt != {CNT_W{1'b1}}))
                r_err_cnt <= r_err_cnt + CNT_W'(1);
        end
    end

    assign err_cnt = r_err_cnt;
`else
    assign err_cnt = '0;
`endif

endmodule

`default_nettype wire
